// File: rtl/serial_fetch_ctrl.sv
// serial_fetch_ctrl: byte-serial instruction fetch sequencer.
// Sends a 16-bit PC low byte first, then receives 2 or 4 instruction bytes.
// The number of bytes depends on the opcode in byte 0.
// Each received byte is forwarded to the shift register as a one-cycle
// data_ready strobe with serial_in.
// Optional feature macro: FETCH_TIMEOUT_EN adds a stall counter that aborts
// a fetch after TIMEOUT_CYCLES cycles with no handshake progress.
//
// Handshake semantics: a byte moves on the clock edge where valid and ready
// are both high. A producer raises valid without waiting for ready. It then
// holds valid and the data stable until that edge. Ready may be high while
// valid is low.
module serial_fetch_ctrl #(
   parameter logic [7:0] LONG_OPC_MASK  = 8'h12
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CYCLES = 255
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] pc,
   input  logic        flush,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  serial_in,
   output logic        data_ready,
   output logic        busy,
   output logic        fetch_done,
   output logic [2:0]  instr_len,
   output logic        timeout,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEND_LO = 3'd1,
      S_SEND_HI = 3'd2,
      S_RECV    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc_q;
   logic [2:0]  count;
   logic        out_xfer, in_xfer, abort, timeout_hit, last_byte, accept;
   logic [2:0]  byte0_len, len_eff;

   assign out_xfer  = ((state == S_SEND_LO) || (state == S_SEND_HI)) && out_ready;
   assign in_xfer   = (state == S_RECV) && in_valid;
   assign abort     = flush || timeout_hit;
   assign accept    = (state == S_IDLE) && fetch_req && !abort;
   // Byte 0 decides the length, so the final-byte test uses the fresh decode
   // on that transfer and the registered length afterwards.
   assign byte0_len = LONG_OPC_MASK[in_byte[2:0]] ? 3'd4 : 3'd2;
   assign len_eff   = (count == 3'd0) ? byte0_len : instr_len;
   assign last_byte = in_xfer && ((count + 3'd1) == len_eff);

   assign busy       = (state != S_IDLE);
   assign fetch_done = (state == S_DONE);
   assign state_dbg  = state;

`ifdef FETCH_TIMEOUT_EN
   logic [15:0] stall_cnt;
   logic        active;

   assign active      = (state == S_SEND_LO) || (state == S_SEND_HI) || (state == S_RECV);
   assign timeout_hit = active && !out_xfer && !in_xfer && (stall_cnt == 16'(TIMEOUT_CYCLES));
   assign timeout     = timeout_hit && !flush;

   // Stall counter: counts cycles without progress in an active state.
   always_ff @(posedge clk) begin
      if (rst || !active || out_xfer || in_xfer || (state_next != state))
         stall_cnt <= 16'd0;
      else
         stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state and bus-side outputs. An abort overrides any handshake progress.
   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      out_byte   = 8'h00;
      in_ready   = 1'b0;
      case (state)
         S_IDLE: begin
            if (fetch_req) state_next = S_SEND_LO;
         end
         S_SEND_LO: begin
            out_valid = 1'b1;
            out_byte  = pc_q[7:0];
            if (out_xfer) state_next = S_SEND_HI;
         end
         S_SEND_HI: begin
            out_valid = 1'b1;
            out_byte  = pc_q[15:8];
            if (out_xfer) state_next = S_RECV;
         end
         S_RECV: begin
            in_ready = 1'b1;
            if (last_byte) state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   // Datapath: PC latch, byte count, length and the shift-register strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= 16'h0000;
         count      <= 3'd0;
         instr_len  <= 3'd0;
         serial_in  <= 8'h00;
         data_ready <= 1'b0;
      end else begin
         data_ready <= in_xfer && !abort;
         if (accept) begin
            pc_q      <= pc;
            instr_len <= 3'd0;
         end
         if (abort || (state != S_RECV))
            count <= 3'd0;
         else if (in_xfer)
            count <= count + 3'd1;
         if (in_xfer && !abort) begin
            serial_in <= in_byte;
            if (count == 3'd0) instr_len <= byte0_len;
         end
      end
   end

endmodule

// File: tb/tb_serial_fetch_ctrl.sv
// Directed bench for serial_fetch_ctrl: fetch lengths, stalls, flush, reset
// and stall behaviour with or without FETCH_TIMEOUT_EN.
module tb_serial_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [15:0] pc = 16'h0000;
   logic        flush = 1'b0;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  serial_in;
   logic        data_ready;
   logic        busy;
   logic        fetch_done;
   logic [2:0]  instr_len;
   logic        timeout;
   logic [2:0]  state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef FETCH_TIMEOUT_EN
   serial_fetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
   serial_fetch_ctrl dut (
`endif
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc), .flush(flush),
      .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
      .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .serial_in(serial_in), .data_ready(data_ready), .busy(busy),
      .fetch_done(fetch_done), .instr_len(instr_len), .timeout(timeout),
      .state_dbg(state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Request a fetch with the bus always ready; returns with the DUT in RECV.
   task automatic start_fetch(input logic [15:0] p);
      fetch_req = 1'b1;
      pc        = p;
      out_ready = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("send_lo_valid", 16'(out_valid), 16'd1);
      chk("send_lo_byte", 16'(out_byte), 16'(p[7:0]));
      tick();
      chk("send_hi_byte", 16'(out_byte), 16'(p[15:8]));
      tick();
      chk("recv_in_ready", 16'(in_ready), 16'd1);
      chk("recv_out_valid", 16'(out_valid), 16'd0);
   endtask

   // Deliver one byte and check the strobe that follows it.
   task automatic rx(input logic [7:0] b, input logic [2:0] len, input logic done);
      in_valid = 1'b1;
      in_byte  = b;
      tick();
      in_valid = 1'b0;
      chk("rx_data_ready", 16'(data_ready), 16'd1);
      chk("rx_serial_in", 16'(serial_in), 16'(b));
      chk("rx_instr_len", 16'(instr_len), 16'(len));
      chk("rx_fetch_done", 16'(fetch_done), 16'(done));
      chk("rx_in_ready", 16'(in_ready), 16'(!done));
   endtask

   initial begin
      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_byte", 16'(out_byte), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_data_ready", 16'(data_ready), 16'd0);
      chk("rst_instr_len", 16'(instr_len), 16'd0);
      chk("rst_serial_in", 16'(serial_in), 16'd0);
      chk("rst_state", 16'(state_dbg), 16'd0);

      // Test 1: short fetch. Opcode 0 gives 2 bytes.
      start_fetch(16'h1234);
      rx(8'h08, 3'd2, 1'b0);
      rx(8'h00, 3'd2, 1'b1);
      tick();
      chk("t1_idle_busy", 16'(busy), 16'd0);
      chk("t1_idle_dr", 16'(data_ready), 16'd0);
      chk("t1_idle_done", 16'(fetch_done), 16'd0);
      chk("t1_len_hold", 16'(instr_len), 16'd2);

      // Test 2: long fetch. Opcode 1 gives 4 bytes.
      // One idle in_valid gap occurs, then an extra byte follows.
      start_fetch(16'h5678);
      rx(8'h01, 3'd4, 1'b0);
      rx(8'h00, 3'd4, 1'b0);
      tick();
      chk("t2_gap_dr", 16'(data_ready), 16'd0);
      chk("t2_gap_busy", 16'(busy), 16'd1);
      rx(8'hCD, 3'd4, 1'b0);
      rx(8'hAB, 3'd4, 1'b1);
      in_valid = 1'b1;
      in_byte  = 8'hEE;
      tick();
      in_valid = 1'b0;
      chk("t2_extra_dr", 16'(data_ready), 16'd0);
      chk("t2_extra_busy", 16'(busy), 16'd0);
      chk("t2_extra_si", 16'(serial_in), 16'hAB);

      // Test 3: out_ready stalls in SEND_LO, then in_valid gaps occur in RECV.
      fetch_req = 1'b1;
      pc        = 16'h1234;
      out_ready = 1'b0;
      tick();
      fetch_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_stall_valid", 16'(out_valid), 16'd1);
         chk("t3_stall_byte", 16'(out_byte), 16'h34);
         tick();
      end
      chk("t3_still_lo", 16'(state_dbg), 16'd1);
      out_ready = 1'b1;
      tick();
      chk("t3_hi_byte", 16'(out_byte), 16'h12);
      tick();
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t3_gap_dr", 16'(data_ready), 16'd0);
      end
      rx(8'h10, 3'd2, 1'b0);
      tick();
      chk("t3_gap2_dr", 16'(data_ready), 16'd0);
      rx(8'h20, 3'd2, 1'b1);
      tick();

      // Test 4: flush after 1 of 4 bytes, while that byte's strobe is still showing.
      start_fetch(16'hBEEF);
      rx(8'h04, 3'd4, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_flush_busy", 16'(busy), 16'd0);
      chk("t4_flush_done", 16'(fetch_done), 16'd0);
      chk("t4_flush_dr", 16'(data_ready), 16'd0);
      tick();
      chk("t4_after_done", 16'(fetch_done), 16'd0);
      fetch_req = 1'b1;
      pc        = 16'h7777;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_req_dropped", 16'(busy), 16'd0);
      pc = 16'h0002;
      tick();
      fetch_req = 1'b0;
      chk("t4_new_lo", 16'(out_byte), 16'h02);
      tick();
      chk("t4_new_hi", 16'(out_byte), 16'h00);
      chk("t4_new_hi_state", 16'(state_dbg), 16'd2);

      // Test 5: reset in SEND_HI clears all state.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_valid", 16'(out_valid), 16'd0);
      chk("t5_rst_byte", 16'(out_byte), 16'd0);
      chk("t5_rst_busy", 16'(busy), 16'd0);
      chk("t5_rst_state", 16'(state_dbg), 16'd0);
      chk("t5_rst_dr", 16'(data_ready), 16'd0);

      // Test 5: fetch_req is ignored while busy, and the latched PC is kept.
      fetch_req = 1'b1;
      pc        = 16'hA5C3;
      out_ready = 1'b0;
      tick();
      pc = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t5_busy_lo", 16'(out_byte), 16'hC3);
      end
      fetch_req = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("t5_busy_hi", 16'(out_byte), 16'hA5);
      tick();
      rx(8'h00, 3'd2, 1'b0);
      rx(8'h00, 3'd2, 1'b1);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t5_done_req_ignored", 16'(busy), 16'd0);

      // Test 6: no handshake progress occurs in RECV.
      start_fetch(16'h4321);
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         chk("t6_no_timeout_yet", 16'(timeout), 16'd0);
         tick();
      end
      chk("t6_timeout_pulse", 16'(timeout), 16'd1);
      tick();
      chk("t6_timeout_idle", 16'(busy), 16'd0);
      chk("t6_timeout_low", 16'(timeout), 16'd0);
      chk("t6_timeout_no_done", 16'(fetch_done), 16'd0);
`else
      for (int i = 0; i < 20; i++) begin
         chk("t6_timeout_tied", 16'(timeout), 16'd0);
         tick();
      end
      chk("t6_still_recv", 16'(state_dbg), 16'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_flush_idle", 16'(busy), 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
